// File: rtl/corner_tracker.sv
// Per-frame corner tracker: captures corner/pink pixel codes during a frame, then on the
// VGA_VS falling edge smooths the captured coordinates into published outputs over five cycles.
`timescale 1ns/1ps
module corner_tracker #(
   parameter int SMOOTH_SHIFT = 2,
   parameter int MISS_LIMIT   = 4,
   parameter int X_MAX        = 639,
   parameter int Y_MAX        = 479
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        VGA_VS,
   input  logic [2:0]  corner_code,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   output logic [9:0]  tl_x,
   output logic [9:0]  tl_y,
   output logic [9:0]  tr_x,
   output logic [9:0]  tr_y,
   output logic [9:0]  bl_x,
   output logic [9:0]  bl_y,
   output logic [9:0]  br_x,
   output logic [9:0]  br_y,
   output logic [3:0]  corners_valid,
   output logic        lock,
   output logic [18:0] pink_count,
   output logic        frame_done
);

   typedef enum logic [2:0] {COLLECT, UPD0, UPD1, UPD2, UPD3, PUBLISH} state_t;

   localparam logic [9:0]  X_LIM     = 10'(X_MAX);
   localparam logic [9:0]  Y_LIM     = 10'(Y_MAX);
   localparam logic [3:0]  MISS_LIM  = 4'(MISS_LIMIT);
   localparam logic [18:0] COUNT_MAX = 19'h7FFFF;

   state_t state, state_next;
   logic   vs_prev, frame_end;
   logic   snapshot, upd_active, publish;

   logic [3:0][9:0] sc_x, sc_y, sc_x_n, sc_y_n;
   logic [3:0]      sc_seen, sc_seen_n;
   logic [18:0]     sc_count, sc_count_n;

   logic [3:0][9:0] sh_x, sh_y;
   logic [3:0]      sh_seen;
   logic [18:0]     sh_count;

   logic [3:0][9:0] w_x, w_y;
   logic [3:0]      valid;
   logic [3:0][3:0] miss;

   logic       in_range, hit_corner, hit_pink;
   logic [1:0] hit_idx, upd_idx;
   logic [3:0] miss_inc;

   // Signed 11-bit IIR step; the floor of >>> keeps the result between w and n.
   function automatic logic [9:0] smooth(input logic [9:0] w, input logic [9:0] n);
      logic signed [10:0] d;
      logic signed [10:0] r;
      d = $signed({1'b0, n}) - $signed({1'b0, w});
      r = $signed({1'b0, w}) + (d >>> SMOOTH_SHIFT);
      return r[9:0];
   endfunction

   assign frame_end  = vs_prev & ~VGA_VS;
   assign in_range   = (pix_x <= X_LIM) && (pix_y <= Y_LIM);
   assign hit_corner = in_range && (corner_code >= 3'd1) && (corner_code <= 3'd4);
   assign hit_pink   = in_range && (corner_code >= 3'd1) && (corner_code <= 3'd5);
   assign hit_idx    = 2'(corner_code - 3'd1);
   assign upd_idx    = 2'(state - UPD0);
   assign miss_inc   = (miss[upd_idx] == 4'hF) ? 4'hF : miss[upd_idx] + 4'd1;
   assign lock       = &corners_valid;

   // NOTE: vs_prev keeps sampling during reset so a sync edge straddling reset is not missed.
   always_ff @(posedge clk) vs_prev <= VGA_VS;

   always_ff @(posedge clk) begin
      if (reset) state <= COLLECT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         COLLECT: if (frame_end) state_next = UPD0;
         UPD0:    state_next = UPD1;
         UPD1:    state_next = UPD2;
         UPD2:    state_next = UPD3;
         UPD3:    state_next = PUBLISH;
         PUBLISH: state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
   end

   always_comb begin
      snapshot   = (state == COLLECT) && frame_end;
      upd_active = (state == UPD0) || (state == UPD1) || (state == UPD2) || (state == UPD3);
      publish    = (state == PUBLISH);
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sc_x_n     = sc_x;
      sc_y_n     = sc_y;
      sc_seen_n  = sc_seen;
      sc_count_n = sc_count;
      if (snapshot) begin
         sc_x_n     = '0;
         sc_y_n     = '0;
         sc_seen_n  = '0;
         sc_count_n = '0;
      end
      if (hit_corner) begin
         sc_x_n[hit_idx]    = pix_x;
         sc_y_n[hit_idx]    = pix_y;
         sc_seen_n[hit_idx] = 1'b1;
      end
      if (hit_pink && (sc_count_n != COUNT_MAX)) sc_count_n = sc_count_n + 19'd1;
   end

   // NOTE: the small coordinate arrays are flops, not RAM, so they are reset with everything else.
   always_ff @(posedge clk) begin
      if (reset) begin
         sc_x <= '0;  sc_y <= '0;  sc_seen <= '0;  sc_count <= '0;
         sh_x <= '0;  sh_y <= '0;  sh_seen <= '0;  sh_count <= '0;
      end else begin
         sc_x <= sc_x_n;  sc_y <= sc_y_n;  sc_seen <= sc_seen_n;  sc_count <= sc_count_n;
         if (snapshot) begin
            sh_x <= sc_x;  sh_y <= sc_y;  sh_seen <= sc_seen;  sh_count <= sc_count;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_x   <= '0;
         w_y   <= '0;
         valid <= '0;
         miss  <= '0;
      end else if (upd_active) begin
         if (sh_seen[upd_idx]) begin
            w_x[upd_idx]   <= valid[upd_idx] ? smooth(w_x[upd_idx], sh_x[upd_idx]) : sh_x[upd_idx];
            w_y[upd_idx]   <= valid[upd_idx] ? smooth(w_y[upd_idx], sh_y[upd_idx]) : sh_y[upd_idx];
            valid[upd_idx] <= 1'b1;
            miss[upd_idx]  <= '0;
         end else begin
            miss[upd_idx] <= miss_inc;
            if (miss_inc >= MISS_LIM) valid[upd_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tl_x <= '0;  tl_y <= '0;  tr_x <= '0;  tr_y <= '0;
         bl_x <= '0;  bl_y <= '0;  br_x <= '0;  br_y <= '0;
         corners_valid <= '0;
         pink_count    <= '0;
         frame_done    <= 1'b0;
      end else begin
         frame_done <= publish;
         if (publish) begin
            tl_x <= w_x[0];  tl_y <= w_y[0];
            tr_x <= w_x[1];  tr_y <= w_y[1];
            bl_x <= w_x[2];  bl_y <= w_y[2];
            br_x <= w_x[3];  br_y <= w_y[3];
            corners_valid <= valid;
            pink_count    <= sh_count;
         end
      end
   end

endmodule
